sqrt_arbiter: RTL

Shares one pipelined square-root core between two pixel-stream requesters, e.g. the gradient-modulus paths of two detection windows. Accepts 17-bit squared magnitudes from each requester and issues them to the core with round-robin arbitration. Tags every issued sample in an in-order FIFO and steers each core result back to the requester that issued it. Sits between the gradient stages and the square-root IP in the CarDetection datapath.

---
 rtl/sqrt_arbiter_if.sv | 34 +++
 rtl/sqrt_arbiter.sv | 104 ++++++++++
 2 files changed

// File: rtl/sqrt_arbiter_if.sv
// Requester, square-root core and result signals of sqrt_arbiter.
// slave is the arbiter's view; master is the requester/core side.
interface sqrt_arbiter_if;
  logic        req0_valid;
  logic        req1_valid;
  logic [16:0] req0_data;
  logic [16:0] req1_data;
  logic        req0_ready;
  logic        req1_ready;
  logic        core_tvalid;
  logic [23:0] core_tdata;
  logic        core_aresetn;
  logic        core_dout_tvalid;
  logic [15:0] core_dout_tdata;
  logic        res0_valid;
  logic        res1_valid;
  logic [15:0] res0_data;
  logic [15:0] res1_data;
  logic        busy;

  modport slave (
    input  req0_valid, req1_valid, req0_data, req1_data,
    input  core_dout_tvalid, core_dout_tdata,
    output req0_ready, req1_ready, core_tvalid, core_tdata, core_aresetn,
    output res0_valid, res1_valid, res0_data, res1_data, busy
  );

  modport master (
    output req0_valid, req1_valid, req0_data, req1_data,
    output core_dout_tvalid, core_dout_tdata,
    input  req0_ready, req1_ready, core_tvalid, core_tdata, core_aresetn,
    input  res0_valid, res1_valid, res0_data, res1_data, busy
  );
endinterface

// File: rtl/sqrt_arbiter.sv
// Round-robin share of one sqrt core by two requesters (SQRT_ARBITER_FIXED_PRIO_EN: req0 always wins ties).
// Latency: issue 1 cycle after accept, result 1 cycle after core_dout_tvalid (core latency + 2 overall).
// Backpressure: readies drop while DEPTH samples are in flight; results are pulses with no backpressure.
module sqrt_arbiter #(
  parameter int DEPTH = 32
) (
  input logic           pclk,
  input logic           aresetn,
  sqrt_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  logic [AW:0]      inflight_q, inflight_d;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [DEPTH-1:0] tag_q;
`ifndef SQRT_ARBITER_FIXED_PRIO_EN
  logic             last_q;
`endif
  logic             core_tvalid_q;
  logic [23:0]      core_tdata_q;
  logic             res0_valid_q, res1_valid_q;
  logic [15:0]      res0_data_q, res1_data_q;
  logic             gnt0, gnt1, accept, pop, pop_tag;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (inflight_q < FULL) begin
`ifdef SQRT_ARBITER_FIXED_PRIO_EN
      gnt0 = bus.req0_valid;
      gnt1 = bus.req1_valid & ~bus.req0_valid;
`else
      // On a tie the requester that was not served last wins.
      gnt0 = bus.req0_valid & (~bus.req1_valid | last_q);
      gnt1 = bus.req1_valid & (~bus.req0_valid | ~last_q);
`endif
    end
  end

  assign accept = gnt0 | gnt1;
  // A result with no outstanding tag is dropped and leaves the counter at 0.
  assign pop     = bus.core_dout_tvalid & (inflight_q != '0);
  assign pop_tag = tag_q[rd_ptr_q];

  always_comb begin
    inflight_d = inflight_q;
    if (accept && !pop) begin
      inflight_d = inflight_q + 1'b1;
    end else if (pop && !accept) begin
      inflight_d = inflight_q - 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge aresetn) begin
    if (!aresetn) begin
      inflight_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      tag_q         <= '0;
`ifndef SQRT_ARBITER_FIXED_PRIO_EN
      last_q        <= 1'b1;
`endif
      core_tvalid_q <= 1'b0;
      core_tdata_q  <= '0;
      res0_valid_q  <= 1'b0;
      res1_valid_q  <= 1'b0;
      res0_data_q   <= '0;
      res1_data_q   <= '0;
    end else begin
      inflight_q    <= inflight_d;
      core_tvalid_q <= accept;
      if (accept) begin
        core_tdata_q    <= {1'b0, (gnt1 ? bus.req1_data : bus.req0_data), 6'b000000};
        tag_q[wr_ptr_q] <= gnt1;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
`ifndef SQRT_ARBITER_FIXED_PRIO_EN
        last_q          <= gnt1;
`endif
      end
      res0_valid_q <= pop & ~pop_tag;
      res1_valid_q <= pop & pop_tag;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        if (pop_tag) begin
          res1_data_q <= bus.core_dout_tdata;
        end else begin
          res0_data_q <= bus.core_dout_tdata;
        end
      end
    end
  end

  assign bus.req0_ready   = gnt0;
  assign bus.req1_ready   = gnt1;
  assign bus.core_tvalid  = core_tvalid_q;
  assign bus.core_tdata   = core_tdata_q;
  assign bus.core_aresetn = aresetn;
  assign bus.res0_valid   = res0_valid_q;
  assign bus.res1_valid   = res1_valid_q;
  assign bus.res0_data    = res0_data_q;
  assign bus.res1_data    = res1_data_q;
  assign bus.busy         = (inflight_q != '0);
endmodule
